spi_shift_engine: RTL and testbench

Parametrised full-duplex SPI shift engine, the successor to the fixed-width shift register in the SPI datapath. It supports a runtime frame length, MSB- or LSB-first ordering, independent sample and drive strobes (so the controller can realise any CPOL/CPHA), and frame completion tracking. Received words go into a holding register with a valid/ack handshake and overrun detection. It sits between the SPI clock/phase controller, which generates the strobes, and the host-side register interface.

---
 rtl/spi_shift_engine_pkg.sv | 13 +
 rtl/spi_shift_engine.sv | 184 ++++++++++++++++++
 tb/tb_spi_shift_engine.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_shift_engine_pkg.sv
// Shared constants for the SPI shift engine: default frame width and state encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_shift_engine_pkg;

  // Default maximum frame width in bits.
  localparam int SPI_DATA_LEN = 8;

  // FSM state encodings, kept as plain constants so legacy code can share them.
  localparam logic [0:0] SPI_SE_IDLE  = 1'b0;
  localparam logic [0:0] SPI_SE_SHIFT = 1'b1;

endpackage

// File: rtl/spi_shift_engine.sv
// Full-duplex SPI shift engine with runtime frame length, bit order and completion tracking.
// Latency: first tx bit valid the cycle after load_en; d_out/rx_valid/done valid the cycle after the final sample.
// Backpressure: none; a completion while rx_valid is unacked overwrites d_out and sets sticky overrun.
module spi_shift_engine
  import spi_shift_engine_pkg::*;
#(
  parameter int DATA_LEN = SPI_DATA_LEN,
  parameter int LEN_W    = $clog2(DATA_LEN) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_LEN-1:0] d_in,
  input  logic [LEN_W-1:0]    frame_len,
  input  logic                lsb_first,
  input  logic                load_en,
  input  logic                abort,
  input  logic                sample_en,
  input  logic                drive_en,
  input  logic                serial_in,
  input  logic                rx_ack,
  output logic                serial_out,
  output logic [DATA_LEN-1:0] d_out,
  output logic                rx_valid,
  output logic                overrun,
  output logic                busy,
  output logic                done
);

  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DATA_LEN);

  logic [0:0]          state_q,    state_d;
  logic [DATA_LEN-1:0] tx_sr_q,    tx_sr_d;
  logic [DATA_LEN-1:0] rx_sr_q,    rx_sr_d;
  logic [LEN_W-1:0]    bit_cnt_q,  bit_cnt_d;
  logic [LEN_W-1:0]    len_q,      len_d;
  logic                lsb_q,      lsb_d;
  logic [DATA_LEN-1:0] d_out_q,    d_out_d;
  logic                rx_valid_q, rx_valid_d;
  logic                overrun_q,  overrun_d;
  logic                done_q,     done_d;

  logic [LEN_W-1:0]    eff_len;
  logic [LEN_W-1:0]    len_m1;
  logic [DATA_LEN-1:0] len_mask;
  logic [DATA_LEN-1:0] rx_shift;
  logic                in_shift;
  logic                last_sample;

  // Resolve the requested frame length: 0 or anything wider than the register means full width.
  always_comb begin
    eff_len = frame_len;
    if ((frame_len == '0) || (frame_len > FULL_LEN)) begin
      eff_len = FULL_LEN;
    end
  end

  // Helpers derived from the latched config: top bit index and a mask of the active bits.
  always_comb begin
    len_m1   = len_q - LEN_W'(1);
    len_mask = '0;
    for (int i = 0; i < DATA_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
  end

  // Receive register after one sample; LSB-first inserts at the top of the active window.
  always_comb begin
    rx_shift = '0;
    if (lsb_q) begin
      rx_shift = rx_sr_q >> 1;
      if (state_q == SPI_SE_SHIFT) begin
        rx_shift[len_m1] = serial_in;
      end
    end else begin
      rx_shift = {rx_sr_q[DATA_LEN-2:0], serial_in};
    end
  end

  // Completion is the final sample of the frame; abort overrides it.
  always_comb begin
    in_shift    = (state_q == SPI_SE_SHIFT);
    last_sample = in_shift && sample_en && !abort && (bit_cnt_q == len_m1);
  end

  // Frame sequencing: load in IDLE, shift/sample in SHIFT, leave on completion or abort.
  always_comb begin
    state_d   = state_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    bit_cnt_d = bit_cnt_q;
    len_d     = len_q;
    lsb_d     = lsb_q;
    case (state_q)
      SPI_SE_IDLE: begin
        if (load_en) begin
          state_d   = SPI_SE_SHIFT;
          tx_sr_d   = d_in;
          len_d     = eff_len;
          lsb_d     = lsb_first;
          rx_sr_d   = '0;
          bit_cnt_d = '0;
        end
      end
      default: begin
        if (abort) begin
          state_d = SPI_SE_IDLE;
        end else begin
          if (sample_en) begin
            rx_sr_d   = rx_shift;
            bit_cnt_d = bit_cnt_q + LEN_W'(1);
          end
          if (drive_en) begin
            tx_sr_d = lsb_q ? (tx_sr_q >> 1) : (tx_sr_q << 1);
          end
          if (last_sample) begin
            state_d = SPI_SE_IDLE;
          end
        end
      end
    endcase
  end

  // Holding register handshake: completion beats a coincident ack, ack clears valid and overrun.
  always_comb begin
    d_out_d    = d_out_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    done_d     = 1'b0;
    if (last_sample) begin
      d_out_d    = rx_shift & len_mask;
      rx_valid_d = 1'b1;
      done_d     = 1'b1;
      if (rx_valid_q && !rx_ack) begin
        overrun_d = 1'b1;
      end else if (rx_ack) begin
        overrun_d = 1'b0;
      end
    end else if (rx_ack) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
  end

  // State registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= SPI_SE_IDLE;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      bit_cnt_q  <= '0;
      len_q      <= '0;
      lsb_q      <= 1'b0;
      d_out_q    <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      bit_cnt_q  <= bit_cnt_d;
      len_q      <= len_d;
      lsb_q      <= lsb_d;
      d_out_q    <= d_out_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      done_q     <= done_d;
    end
  end

  // Outputs; serial_out is forced low outside a frame.
  always_comb begin
    serial_out = 1'b0;
    if (in_shift) begin
      serial_out = lsb_q ? tx_sr_q[0] : tx_sr_q[len_m1];
    end
    d_out    = d_out_q;
    rx_valid = rx_valid_q;
    overrun  = overrun_q;
    busy     = in_shift;
    done     = done_q;
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine with a frame-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_shift_engine;

  localparam int DL = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DL-1:0] d_in;
  logic [LW-1:0] frame_len;
  logic          lsb_first, load_en, abort, sample_en, drive_en, serial_in, rx_ack;
  logic          serial_out, rx_valid, overrun, busy, done;
  logic [DL-1:0] d_out;

  spi_shift_engine #(.DATA_LEN(DL), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .frame_len(frame_len), .lsb_first(lsb_first),
    .load_en(load_en), .abort(abort), .sample_en(sample_en), .drive_en(drive_en),
    .serial_in(serial_in), .rx_ack(rx_ack), .serial_out(serial_out), .d_out(d_out),
    .rx_valid(rx_valid), .overrun(overrun), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a frame is a word, a length, an order, a count of bits driven and a list of bits received.
  logic          m_busy, m_lsb, m_valid, m_ovr, m_done;
  logic [DL-1:0] m_word, m_dout;
  int            m_len, m_drv;
  logic          m_bits[$];

  task automatic m_reset();
    m_busy = 0; m_lsb = 0; m_valid = 0; m_ovr = 0; m_done = 0;
    m_word = '0; m_dout = '0; m_len = 0; m_drv = 0;
    m_bits.delete();
  endtask

  function automatic logic m_sout();
    if (!m_busy) return 1'b0;
    if (m_lsb) return (m_drv < DL) ? m_word[m_drv] : 1'b0;
    return (m_drv < m_len) ? m_word[m_len - 1 - m_drv] : 1'b0;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic m_edge();
    int fl;
    int v;
    logic complete;
    m_done = 0;
    complete = 0;
    if (!m_busy) begin
      if (load_en) begin
        fl = int'(frame_len);
        m_len = (fl == 0 || fl > DL) ? DL : fl;
        m_busy = 1; m_word = d_in; m_lsb = lsb_first; m_drv = 0;
        m_bits.delete();
      end
    end else if (abort) begin
      m_busy = 0;
    end else begin
      complete = sample_en && (m_bits.size() == m_len - 1);
      if (sample_en) m_bits.push_back(serial_in);
      if (drive_en) m_drv++;
      if (complete) begin
        v = 0;
        for (int i = 0; i < m_len; i++)
          if (m_bits[i]) v += m_lsb ? (1 << i) : (1 << (m_len - 1 - i));
        m_dout = DL'(v);
        if (m_valid && !rx_ack) m_ovr = 1;
        else if (rx_ack) m_ovr = 0;
        m_valid = 1; m_done = 1; m_busy = 0;
      end
    end
    if (!complete && rx_ack) begin
      m_valid = 0; m_ovr = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("serial_out", 32'(serial_out), 32'(m_sout()));
    chk("d_out",      32'(d_out),      32'(m_dout));
    chk("rx_valid",   32'(rx_valid),   32'(m_valid));
    chk("overrun",    32'(overrun),    32'(m_ovr));
    chk("busy",       32'(busy),       32'(m_busy));
    chk("done",       32'(done),       32'(m_done));
  endtask

  // One clock: apply inputs, let the edge happen, update the model, compare on the falling edge.
  task automatic step(input logic ld, input logic [DL-1:0] dv, input logic [LW-1:0] fl,
                      input logic lb, input logic ab, input logic se, input logic de,
                      input logic ack, input logic loop, input logic si);
    load_en = ld; d_in = dv; frame_len = fl; lsb_first = lb; abort = ab;
    sample_en = se; drive_en = de; rx_ack = ack;
    serial_in = loop ? m_sout() : si;
    @(posedge clk);
    m_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic load(input logic [DL-1:0] dv, input logic [LW-1:0] fl, input logic lb);
    step(1, dv, fl, lb, 0, 0, 0, 0, 0, 0);
  endtask

  // Sample+drive strobe with serial_out looped back to serial_in.
  task automatic xfer(input logic ack);
    step(0, '0, '0, 0, 0, 1, 1, ack, 1, 0);
  endtask

  task automatic idle(input logic ack);
    step(0, '0, '0, 0, 0, 0, 0, ack, 0, 0);
  endtask

  initial begin
    logic [7:0] pat;
    logic [4:0] pat5;
    logic [LW-1:0] flens[2];
    rst = 0;
    d_in = '0; frame_len = '0; lsb_first = 0; load_en = 0; abort = 0;
    sample_en = 0; drive_en = 0; serial_in = 0; rx_ack = 0;
    m_reset();
    #1;
    compare_all();
    @(negedge clk);
    @(negedge clk);
    rst = 1;

    // MSB-first receive of 11001101.
    pat = 8'b11001101;
    load(8'h00, 4'd8, 0);
    for (int i = 7; i >= 0; i--) step(0, '0, '0, 0, 0, 1, 0, 0, 0, pat[i]);
    chk("t1_dout", 32'(d_out), 32'hCD);
    chk("t1_done", 32'(done), 1);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_valid", 32'(rx_valid), 1);
    idle(1);
    chk("t1_done_pulse", 32'(done), 0);

    // MSB-first transmit of A5, with a load of FF attempted mid-frame.
    pat = 8'hA5;
    load(8'hA5, 4'd8, 0);
    chk("t2_bit7", 32'(serial_out), 32'(pat[7]));
    for (int i = 6; i >= 0; i--) begin
      if (i == 4) step(1, 8'hFF, 4'd8, 0, 0, 1, 1, 0, 1, 0);
      else xfer(0);
      chk("t2_bit", 32'(serial_out), 32'(pat[i]));
    end
    xfer(0);
    chk("t2_idle_out", 32'(serial_out), 0);
    chk("t2_dout", 32'(d_out), 32'hA5);
    idle(1);

    // LSB-first, length 5, loopback.
    pat5 = 5'b10110;
    load(8'h16, 4'd5, 1);
    chk("t3_bit0", 32'(serial_out), 32'(pat5[0]));
    for (int i = 1; i < 5; i++) begin
      xfer(0);
      chk("t3_bit", 32'(serial_out), 32'(pat5[i]));
    end
    xfer(0);
    chk("t3_dout", 32'(d_out), 32'h16);
    chk("t3_done", 32'(done), 1);
    idle(1);

    // Overrun: two frames without ack, then ack, then ack coinciding with completion.
    load(8'h3C, 4'd8, 0);
    repeat (8) xfer(0);
    load(8'hC3, 4'd8, 0);
    repeat (8) xfer(0);
    chk("t4_ovr", 32'(overrun), 1);
    chk("t4_dout", 32'(d_out), 32'hC3);
    idle(1);
    chk("t4_ack_valid", 32'(rx_valid), 0);
    chk("t4_ack_ovr", 32'(overrun), 0);
    load(8'h3C, 4'd8, 0);
    repeat (8) xfer(0);
    load(8'hC3, 4'd8, 0);
    repeat (7) xfer(0);
    xfer(1);
    chk("t4_coinc_valid", 32'(rx_valid), 1);
    chk("t4_coinc_ovr", 32'(overrun), 0);
    idle(1);

    // Abort after 3 bits, then abort coinciding with the final sample.
    load(8'h81, 4'd8, 0);
    repeat (3) xfer(0);
    step(0, '0, '0, 0, 1, 0, 0, 0, 0, 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_done", 32'(done), 0);
    chk("t5_dout", 32'(d_out), 32'hC3);
    load(8'h02, 4'd2, 0);
    xfer(0);
    step(0, '0, '0, 0, 1, 1, 1, 0, 1, 0);
    chk("t5_prio_done", 32'(done), 0);
    chk("t5_prio_dout", 32'(d_out), 32'hC3);
    idle(0);

    // Asynchronous reset mid-frame, checked before any clock edge.
    load(8'hF0, 4'd8, 0);
    repeat (3) xfer(0);
    #2;
    rst = 0;
    m_reset();
    #1;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_dout", 32'(d_out), 0);
    compare_all();
    @(negedge clk);
    rst = 1;
    idle(0);

    // Out-of-range frame lengths run the full width.
    flens[0] = 4'd0;
    flens[1] = 4'd12;
    for (int k = 0; k < 2; k++) begin
      load(8'h5A, flens[k], 0);
      repeat (7) xfer(0);
      chk("t7_busy7", 32'(busy), 1);
      xfer(1);
      chk("t7_done", 32'(done), 1);
      chk("t7_dout", 32'(d_out), 32'h5A);
      idle(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
